// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer for the single-cycle RV32 core.
// Holds the core in reset for RST_CYCLES cycles, then gates its progress with
// a per-cycle enable driven by RUN/STEP/HALT/RESET commands and a PC
// breakpoint. Retired instructions are counted one per enabled cycle.
module cpu_run_ctrl #(
   parameter int RST_CYCLES = 4,
   parameter int STEP_W     = 16,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_arg,
   input  logic              bp_en,
   input  logic [31:0]       bp_addr,
   input  logic [31:0]       pc,
   output logic              cpu_rst,
   output logic              cpu_en,
   output logic [1:0]        state,
   output logic              halt_evt,
   output logic [1:0]        halt_cause,
   output logic [CNT_W-1:0]  retired
);

   localparam logic [1:0] S_CPU_RST = 2'd0;
   localparam logic [1:0] S_HALTED  = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;
   localparam logic [1:0] S_STEP    = 2'd3;

   localparam logic [1:0] OP_RESET = 2'd0;
   localparam logic [1:0] OP_RUN   = 2'd1;
   localparam logic [1:0] OP_STEP  = 2'd2;
   localparam logic [1:0] OP_HALT  = 2'd3;

   localparam logic [1:0] CAUSE_CMD  = 2'd0;
   localparam logic [1:0] CAUSE_BP   = 2'd1;
   localparam logic [1:0] CAUSE_STEP = 2'd2;

   // Reset counter counts RST_CYCLES-1 down to 0; keep at least one bit.
   localparam int             RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

   logic [RC_W-1:0]   rst_cnt;
   logic [STEP_W-1:0] steps;
   logic              bp_skip;

   logic active;
   logic fire;
   logic fire_reset;
   logic fire_run;
   logic fire_step;
   logic fire_halt;
   logic bp_hit;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Command handshake, breakpoint detection and core enable.
   always_comb begin
      active     = (state == S_RUN) || (state == S_STEP);
      cmd_ready  = (state != S_CPU_RST);
      fire       = cmd_valid & cmd_ready;
      fire_reset = fire & (cmd_op == OP_RESET);
      fire_run   = fire & (cmd_op == OP_RUN);
      fire_step  = fire & (cmd_op == OP_STEP);
      fire_halt  = fire & (cmd_op == OP_HALT);
      // bp_skip lets the core step off a breakpoint PC it was halted on.
      bp_hit     = bp_en & (pc == bp_addr) & ~bp_skip & active;
      cpu_en     = active & ~bp_hit & ~fire_reset & ~fire_halt;
   end

   // Sequencer state, reset timing, step countdown and halt reporting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_CPU_RST;
         rst_cnt    <= RC_LOAD;
         cpu_rst    <= 1'b1;
         halt_evt   <= 1'b0;
         halt_cause <= CAUSE_CMD;
         steps      <= '0;
         bp_skip    <= 1'b0;
      end else begin
         halt_evt <= 1'b0;
         if (cpu_en) begin
            bp_skip <= 1'b0;
         end
         case (state)
            S_CPU_RST: begin
               if (rst_cnt == '0) begin
                  state   <= S_HALTED;
                  cpu_rst <= 1'b0;
               end else begin
                  rst_cnt <= rst_cnt - 1'b1;
               end
            end
            S_HALTED: begin
               if (fire_reset) begin
                  state   <= S_CPU_RST;
                  rst_cnt <= RC_LOAD;
                  cpu_rst <= 1'b1;
               end else if (fire_run) begin
                  state   <= S_RUN;
                  bp_skip <= 1'b1;
               end else if (fire_step && (cmd_arg != '0)) begin
                  state   <= S_STEP;
                  steps   <= cmd_arg;
                  bp_skip <= 1'b1;
               end
            end
            default: begin
               // RUN or STEP; RUN/STEP commands arriving here are ignored.
               if (fire_reset) begin
                  state   <= S_CPU_RST;
                  rst_cnt <= RC_LOAD;
                  cpu_rst <= 1'b1;
               end else if (bp_hit) begin
                  state      <= S_HALTED;
                  halt_evt   <= 1'b1;
                  halt_cause <= CAUSE_BP;
               end else if (fire_halt) begin
                  state      <= S_HALTED;
                  halt_evt   <= 1'b1;
                  halt_cause <= CAUSE_CMD;
               end else if ((state == S_STEP) && cpu_en) begin
                  if (steps == STEP_W'(1)) begin
                     state      <= S_HALTED;
                     halt_evt   <= 1'b1;
                     halt_cause <= CAUSE_STEP;
                  end else begin
                     steps <= steps - 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Retired-instruction counter: one per enabled cycle, cleared by RESET.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired <= '0;
      end else if (fire_reset) begin
         retired <= '0;
      end else if (cpu_en) begin
         retired <= sat_inc(retired);
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: expected values are queued as each step
// is driven and drained against the DUT outputs once they settle.
module tb_cpu_run_ctrl;

   localparam int RST_CYCLES = 4;
   localparam int STEP_W     = 16;
   localparam int CNT_W      = 4;

   logic              clk;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [STEP_W-1:0] cmd_arg;
   logic              bp_en;
   logic [31:0]       bp_addr;
   logic [31:0]       pc;
   logic              cpu_rst;
   logic              cpu_en;
   logic [1:0]        state;
   logic              halt_evt;
   logic [1:0]        halt_cause;
   logic [CNT_W-1:0]  retired;

   int errors = 0;
   int checks = 0;

   typedef enum int {S_STATE, S_CPURST, S_EN, S_RDY, S_EVT, S_CAUSE, S_RET} sig_e;
   typedef struct {
      string       tag;
      sig_e        sig;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   cpu_run_ctrl #(
      .RST_CYCLES(RST_CYCLES),
      .STEP_W    (STEP_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .bp_en     (bp_en),
      .bp_addr   (bp_addr),
      .pc        (pc),
      .cpu_rst   (cpu_rst),
      .cpu_en    (cpu_en),
      .state     (state),
      .halt_evt  (halt_evt),
      .halt_cause(halt_cause),
      .retired   (retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   function automatic logic [31:0] obs(input sig_e s);
      case (s)
         S_STATE:  return 32'(state);
         S_CPURST: return 32'(cpu_rst);
         S_EN:     return 32'(cpu_en);
         S_RDY:    return 32'(cmd_ready);
         S_EVT:    return 32'(halt_evt);
         S_CAUSE:  return 32'(halt_cause);
         default:  return 32'(retired);
      endcase
   endfunction

   task automatic push_exp(input string tag, input sig_e s, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.sig);
         checks++;
         assert (o === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic v, input logic [1:0] op, input logic [STEP_W-1:0] arg);
      cmd_valid = v;
      cmd_op    = op;
      cmd_arg   = arg;
      #1;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;
      bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0;
      #2;
      // 1: reset values and reset duration
      push_exp("rst_state", S_STATE, 0);
      push_exp("rst_cpu_rst", S_CPURST, 1);
      push_exp("rst_en", S_EN, 0);
      push_exp("rst_ready", S_RDY, 0);
      push_exp("rst_evt", S_EVT, 0);
      push_exp("rst_cause", S_CAUSE, 0);
      push_exp("rst_retired", S_RET, 0);
      check_all();
      cyc();
      rst = 1'b0;
      #1;
      push_exp("t1_cpu_rst_c0", S_CPURST, 1);
      check_all();
      for (int i = 1; i < RST_CYCLES; i++) begin
         cyc();
         push_exp($sformatf("t1_cpu_rst_c%0d", i), S_CPURST, 1);
         push_exp($sformatf("t1_state_c%0d", i), S_STATE, 0);
         push_exp($sformatf("t1_ready_c%0d", i), S_RDY, 0);
         check_all();
      end
      cyc();
      push_exp("t1_halted", S_STATE, 1);
      push_exp("t1_cpu_rst_low", S_CPURST, 0);
      push_exp("t1_en", S_EN, 0);
      push_exp("t1_retired", S_RET, 0);
      push_exp("t1_ready", S_RDY, 1);
      check_all();

      // 2: STEP n=3
      cmd(1'b1, 2'd2, 16'd3);
      push_exp("t2_en_halted", S_EN, 0);
      check_all();
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      for (int i = 0; i < 3; i++) begin
         push_exp($sformatf("t2_state_s%0d", i), S_STATE, 3);
         push_exp($sformatf("t2_en_s%0d", i), S_EN, 1);
         push_exp($sformatf("t2_evt_s%0d", i), S_EVT, 0);
         check_all();
         cyc();
      end
      push_exp("t2_halted", S_STATE, 1);
      push_exp("t2_en_off", S_EN, 0);
      push_exp("t2_evt", S_EVT, 1);
      push_exp("t2_cause", S_CAUSE, 2);
      push_exp("t2_retired", S_RET, 3);
      check_all();
      cyc();
      push_exp("t2_evt_pulse", S_EVT, 0);
      push_exp("t2_still_halted", S_STATE, 1);
      check_all();

      // 3: RUN into a breakpoint, then resume from it
      bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h8;
      cmd(1'b1, 2'd1, 16'd0);
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("t3_run", S_STATE, 2);
      push_exp("t3_en_08", S_EN, 1);
      check_all();
      cyc();
      pc = 32'hC; #1;
      push_exp("t3_en_0c", S_EN, 1);
      check_all();
      cyc();
      pc = 32'h10; #1;
      push_exp("t3_en_bp", S_EN, 0);
      push_exp("t3_state_bp", S_STATE, 2);
      check_all();
      cyc();
      push_exp("t3_halted", S_STATE, 1);
      push_exp("t3_evt", S_EVT, 1);
      push_exp("t3_cause", S_CAUSE, 1);
      push_exp("t3_retired", S_RET, 5);
      check_all();
      cmd(1'b1, 2'd1, 16'd0);
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("t3_resume_state", S_STATE, 2);
      push_exp("t3_resume_en_10", S_EN, 1);
      check_all();
      cyc();
      pc = 32'h14; #1;
      push_exp("t3_en_14", S_EN, 1);
      push_exp("t3_retired_6", S_RET, 6);
      check_all();
      cyc();

      // 5b: RUN while in RUN is ignored
      pc = 32'h18;
      cmd(1'b1, 2'd1, 16'd0);
      push_exp("t5_run_in_run_en", S_EN, 1);
      push_exp("t5_run_in_run_rdy", S_RDY, 1);
      check_all();
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("t5_still_run", S_STATE, 2);
      push_exp("t5_retired_8", S_RET, 8);
      check_all();

      // HALT command after a breakpoint halt
      pc = 32'h1C;
      cmd(1'b1, 2'd3, 16'd0);
      push_exp("th_en_accept", S_EN, 0);
      check_all();
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("th_halted", S_STATE, 1);
      push_exp("th_cause", S_CAUSE, 0);
      push_exp("th_evt", S_EVT, 1);
      push_exp("th_retired", S_RET, 8);
      check_all();
      cyc();

      // 5a: STEP n=0 in HALTED has no effect
      cmd(1'b1, 2'd2, 16'd0);
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("t5_step0_state", S_STATE, 1);
      push_exp("t5_step0_evt", S_EVT, 0);
      push_exp("t5_step0_en", S_EN, 0);
      check_all();

      // RESET from HALTED clears retired
      cmd(1'b1, 2'd0, 16'd0);
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("tr_state", S_STATE, 0);
      push_exp("tr_cpu_rst", S_CPURST, 1);
      push_exp("tr_retired", S_RET, 0);
      push_exp("tr_ready", S_RDY, 0);
      check_all();
      for (int i = 1; i < RST_CYCLES; i++) cyc();
      push_exp("tr_cpu_rst_last", S_CPURST, 1);
      check_all();
      cyc();
      push_exp("tr_halted", S_STATE, 1);
      push_exp("tr_cpu_rst_low", S_CPURST, 0);
      check_all();

      // 4: RUN, HALT accepted on cycle 7
      bp_en = 1'b0;
      cmd(1'b1, 2'd1, 16'd0);
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      for (int i = 1; i <= 6; i++) begin
         push_exp($sformatf("t4_en_c%0d", i), S_EN, 1);
         check_all();
         cyc();
      end
      cmd(1'b1, 2'd3, 16'd0);
      push_exp("t4_en_c7", S_EN, 0);
      push_exp("t4_state_c7", S_STATE, 2);
      check_all();
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("t4_halted", S_STATE, 1);
      push_exp("t4_retired", S_RET, 6);
      push_exp("t4_cause", S_CAUSE, 0);
      push_exp("t4_evt", S_EVT, 1);
      check_all();

      // 6a: RESET while stepping with steps=5
      cmd(1'b1, 2'd2, 16'd5);
      cyc();
      cmd(1'b1, 2'd0, 16'd0);
      push_exp("t6_state_step", S_STATE, 3);
      push_exp("t6_en_reset", S_EN, 0);
      check_all();
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("t6_state_rst", S_STATE, 0);
      push_exp("t6_retired", S_RET, 0);
      push_exp("t6_evt", S_EVT, 0);
      push_exp("t6_cpu_rst", S_CPURST, 1);
      check_all();
      for (int i = 1; i < RST_CYCLES; i++) begin
         cyc();
         push_exp($sformatf("t6_cpu_rst_c%0d", i), S_CPURST, 1);
         check_all();
      end
      cyc();
      push_exp("t6_halted", S_STATE, 1);
      push_exp("t6_evt_after", S_EVT, 0);
      check_all();

      // 6b: RESET in the same cycle as a breakpoint hit
      bp_en = 1'b1; bp_addr = 32'h40; pc = 32'h3C;
      cmd(1'b1, 2'd2, 16'd5);
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("t6b_en_3c", S_EN, 1);
      check_all();
      cyc();
      pc = 32'h40;
      cmd(1'b1, 2'd0, 16'd0);
      push_exp("t6b_en_bp_reset", S_EN, 0);
      check_all();
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      push_exp("t6b_state", S_STATE, 0);
      push_exp("t6b_evt", S_EVT, 0);
      push_exp("t6b_cause", S_CAUSE, 0);
      push_exp("t6b_retired", S_RET, 0);
      check_all();
      for (int i = 0; i < RST_CYCLES; i++) cyc();
      push_exp("t6b_halted", S_STATE, 1);
      check_all();

      // Retired counter saturates at all-ones
      bp_en = 1'b0;
      cmd(1'b1, 2'd1, 16'd0);
      cyc();
      cmd(1'b0, 2'd0, 16'd0);
      for (int i = 0; i < 20; i++) cyc();
      push_exp("ts_retired_sat", S_RET, 15);
      push_exp("ts_state", S_STATE, 2);
      check_all();

      // Async rst mid-RUN aborts immediately
      #2;
      rst = 1'b1;
      #1;
      push_exp("ta_state", S_STATE, 0);
      push_exp("ta_cpu_rst", S_CPURST, 1);
      push_exp("ta_en", S_EN, 0);
      push_exp("ta_retired", S_RET, 0);
      push_exp("ta_evt", S_EVT, 0);
      check_all();
      cyc();
      rst = 1'b0;
      push_exp("ta_evt_after", S_EVT, 0);
      check_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
